// File: rtl/tt_checker_pkg.sv
// Shared types and constants for the 2-input stimulus/response checker.
package tt_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_DONE
   } state_e;

   localparam int unsigned NUM_VECTORS = 4;
   localparam int unsigned IDX_W       = 2;

   typedef logic [IDX_W-1:0] idx_t;

   localparam idx_t LAST_IDX = idx_t'(NUM_VECTORS - 1);

endpackage

// File: rtl/tt_hold_timer.sv
// Reloading down-counter: pulses tc_o on the last cycle of each HOLD_CYCLES-long hold.
module tt_hold_timer #(
   parameter int unsigned HOLD_CYCLES = 10
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(HOLD_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = LOAD;
      end else if (en_i) begin
         cnt_d = (cnt_q == '0) ? LOAD : cnt_q - CNT_W'(1);
      end
   end

   assign tc_o = en_i && !clear_i && (cnt_q == '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tt_stimulus_checker.sv
// Drives vectors 00,01,10,11 into a 2-input unit, samples each response after a hold and
// checks against EXPECTED. Define TT_CHECKER_STOP_ON_FAIL_EN to end a run at the first mismatch.
module tt_stimulus_checker
   import tt_checker_pkg::*;
#(
   parameter int unsigned             HOLD_CYCLES = 10,
   parameter logic [NUM_VECTORS-1:0] EXPECTED    = 4'b0110
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   a,
   output logic                   b,
   input  logic                   dut_out,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [NUM_VECTORS-1:0] captured,
   output logic [NUM_VECTORS-1:0] mismatch
);

`ifdef TT_CHECKER_STOP_ON_FAIL_EN
   localparam bit StopOnFail = 1'b1;
`else
   localparam bit StopOnFail = 1'b0;
`endif

   state_e                 state_q;
   idx_t                   idx_q;
   logic                   a_q, b_q, busy_q, done_q, pass_q;
   logic [NUM_VECTORS-1:0] captured_q, mismatch_q;

   logic accept;
   logic sample;
   logic miss;
   idx_t idx_d;

   assign accept = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
   assign miss   = dut_out ^ EXPECTED[idx_q];
   assign idx_d  = idx_q + idx_t'(1);

   tt_hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_timer (
      .clk_i   (clk),
      .rst_i   (rst),
      .clear_i (accept),
      .en_i    (state_q == ST_DRIVE),
      .tc_o    (sample)
   );

   // Stimulus is registered from the next index, so vector k is on the pins for the H cycles before its sample edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         a_q        <= 1'b0;
         b_q        <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         captured_q <= '0;
         mismatch_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q    <= ST_DRIVE;
                  idx_q      <= '0;
                  a_q        <= 1'b0;
                  b_q        <= 1'b0;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  pass_q     <= 1'b0;
                  captured_q <= '0;
                  mismatch_q <= '0;
               end
            end
            ST_DRIVE: begin
               if (sample) begin
                  captured_q[idx_q] <= dut_out;
                  mismatch_q[idx_q] <= miss;
                  if ((idx_q == LAST_IDX) || (StopOnFail && miss)) begin
                     state_q <= ST_DONE;
                     a_q     <= 1'b0;
                     b_q     <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (mismatch_q == '0) && !miss;
                  end else begin
                     idx_q <= idx_d;
                     a_q   <= idx_d[1];
                     b_q   <= idx_d[0];
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign a        = a_q;
   assign b        = b_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign captured = captured_q;
   assign mismatch = mismatch_q;

endmodule

// File: tb/tb_tt_stimulus_checker.sv
// Bench for tt_stimulus_checker: table vectors, randomized unit truth tables, and hand sequences.
module tb_tt_stimulus_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start0, start1;
   logic [3:0] tt0, tt1;

   logic       a0, b0, busy0, done0, pass0, dout0;
   logic [3:0] cap0, mis0;
   logic       a1, b1, busy1, done1, pass1, dout1;
   logic [3:0] cap1, mis1;

   // Model combinational units: output for vector {a,b} is bit {a,b} of the truth table
   assign dout0 = tt0[{a0, b0}];
   assign dout1 = tt1[{a1, b1}];

   tt_stimulus_checker #(
      .HOLD_CYCLES (10),
      .EXPECTED    (4'b0110)
   ) dut0 (
      .clk      (clk),
      .rst      (rst),
      .start    (start0),
      .a        (a0),
      .b        (b0),
      .dut_out  (dout0),
      .busy     (busy0),
      .done     (done0),
      .pass     (pass0),
      .captured (cap0),
      .mismatch (mis0)
   );

   tt_stimulus_checker #(
      .HOLD_CYCLES (1),
      .EXPECTED    (4'b1110)
   ) dut1 (
      .clk      (clk),
      .rst      (rst),
      .start    (start1),
      .a        (a1),
      .b        (b1),
      .dut_out  (dout1),
      .busy     (busy1),
      .done     (done1),
      .pass     (pass1),
      .captured (cap1),
      .mismatch (mis1)
   );

   typedef struct packed {
      logic       a;
      logic       b;
      logic       busy;
      logic       done;
      logic       pass;
      logic [3:0] cap;
      logic [3:0] mis;
   } obs_t;

   typedef struct {
      int unsigned inst;
      logic [3:0]  tt;
      logic [3:0]  cap;
      logic [3:0]  mis;
      logic        pass;
      int unsigned lat;
      string       name;
   } vec_t;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   function automatic obs_t obs(input int unsigned inst);
      obs_t o;
      if (inst == 0) o = '{a0, b0, busy0, done0, pass0, cap0, mis0};
      else           o = '{a1, b1, busy1, done1, pass1, cap1, mis1};
      return o;
   endfunction

   function automatic int unsigned hof(input int unsigned inst);
      return (inst == 0) ? 10 : 1;
   endfunction

   function automatic logic [3:0] eof(input int unsigned inst);
      return (inst == 0) ? 4'b0110 : 4'b1110;
   endfunction

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
   endtask

   task automatic set_start(input int unsigned inst, input logic v);
      if (inst == 0) start0 = v;
      else           start1 = v;
   endtask

   // Reference: sample vectors in order; optionally stop after the first wrong one
   task automatic model(input int unsigned inst, input logic [3:0] tt,
                        output logic [3:0] cap, output logic [3:0] mis,
                        output logic pass, output int unsigned lat);
      int unsigned nvec;
      logic [3:0]  e;
      logic [3:0]  mask;
      e    = eof(inst);
      nvec = 4;
`ifdef TT_CHECKER_STOP_ON_FAIL_EN
      for (int k = 3; k >= 0; k--) if (tt[k] != e[k]) nvec = k + 1;
`endif
      mask = 4'((5'd1 << nvec) - 5'd1);
      cap  = tt & mask;
      mis  = (tt ^ e) & mask;
      pass = (tt == e);
      lat  = nvec * hof(inst) + 1;
   endtask

   task automatic run_check(input int unsigned inst, input logic [3:0] tt,
                            input logic [3:0] ecap, input logic [3:0] emis,
                            input logic epass, input int unsigned elat, input string tag);
      int unsigned h;
      int unsigned n;
      int unsigned stim_err;
      obs_t        o;
      h = hof(inst);
      if (inst == 0) tt0 = tt;
      else           tt1 = tt;
      @(negedge clk);
      set_start(inst, 1'b1);
      n        = 0;
      stim_err = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
         set_start(inst, 1'b0);
         o = obs(inst);
         // After edge j of the run, vector j/H is on the pins until the run ends
         if (n < elat) begin
            if ({o.a, o.b} != 2'((n - 1) / h) || !o.busy || o.done) stim_err++;
         end else begin
            if ({o.a, o.b} != 2'b00 || o.busy) stim_err++;
         end
      end while (!o.done && n < 4 * h + 20);
      check({tag, " latency"},  n, elat);
      check({tag, " done"},     o.done, 1);
      check({tag, " captured"}, o.cap, ecap);
      check({tag, " mismatch"}, o.mis, emis);
      check({tag, " pass"},     o.pass, epass);
      check({tag, " stimulus"}, stim_err, 0);
   endtask

   vec_t        tbl[4];
   logic [3:0]  mcap, mmis, rtt;
   logic        mpass;
   int unsigned mlat, n;

   initial begin
      tbl[0] = '{0, 4'b0110, 4'b0110, 4'b0000, 1'b1, 41, "xor_h10"};
      tbl[2] = '{1, 4'b1110, 4'b1110, 4'b0000, 1'b1, 5,  "or_h1"};
`ifdef TT_CHECKER_STOP_ON_FAIL_EN
      tbl[1] = '{0, 4'b1000, 4'b0000, 4'b0010, 1'b0, 21, "and_h10"};
      tbl[3] = '{0, 4'b0111, 4'b0001, 4'b0001, 1'b0, 11, "nand_h10"};
`else
      tbl[1] = '{0, 4'b1000, 4'b1000, 4'b1110, 1'b0, 41, "and_h10"};
      tbl[3] = '{0, 4'b0111, 4'b0111, 4'b0001, 1'b0, 41, "nand_h10"};
`endif

      rst    = 1'b1;
      start0 = 1'b0;
      start1 = 1'b0;
      tt0    = 4'b0110;
      tt1    = 4'b1110;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset0 outputs", obs(0), 0);
      check("reset1 outputs", obs(1), 0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++)
         run_check(tbl[i].inst, tbl[i].tt, tbl[i].cap, tbl[i].mis, tbl[i].pass, tbl[i].lat, tbl[i].name);

      for (int i = 0; i < 12; i++) begin
         rtt = 4'($urandom_range(0, 15));
         model(i % 2, rtt, mcap, mmis, mpass, mlat);
         run_check(i % 2, rtt, mcap, mmis, mpass, mlat, $sformatf("rand%0d", i));
      end

      // Reset in the middle of a run: no partial result survives
      tt0 = 4'b0110;
      @(negedge clk);
      start0 = 1'b1;
      for (int i = 0; i < 17; i++) begin
         @(posedge clk);
         @(negedge clk);
         start0 = 1'b0;
      end
      check("midrun busy before rst", busy0, 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrun rst outputs", obs(0), 0);
      rst = 1'b0;
      run_check(0, 4'b0110, 4'b0110, 4'b0000, 1'b1, 41, "after_rst");

      // rst and start together from DONE: rst wins
      start0 = 1'b1;
      rst    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_start outputs", obs(0), 0);
      start0 = 1'b0;
      rst    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_start stays idle", busy0, 0);

      // start held high: one run, then immediate restart from DONE
      tt1 = 4'b1110;
      start1 = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!done1 && n < 30);
      check("held latency", n, 5);
      check("held pass", pass1, 1);
      @(posedge clk);
      @(negedge clk);
      check("held restart busy", busy1, 1);
      check("held restart done", done1, 0);
      start1 = 1'b0;
      n = 0;
      while (!done1 && n < 30) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      check("held rerun latency", n, 4);
      check("held rerun captured", cap1, 4'b1110);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/tt_stimulus_checker.md
# tt_stimulus_checker

Self-checking stimulus/response engine for 2-input combinational units under test in the lab flow. On `start` it drives every input pair (a,b) = 00, 01, 10, 11, holds each for a fixed number of cycles, and samples the unit's output at the end of each hold. It compares the four captured bits against an expected truth table and reports pass/fail. It is the capture-and-check end of the 2-input stimulus interface, synthesizable so checks run on-board as well as in simulation.

## Interface
- `HOLD_CYCLES`, 10: cycles each input vector is held before its response is sampled; legal range ≥ 1.
- `EXPECTED`, 4'b0110: expected truth table; bit k is the required output for vector k = {a,b}.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run; honoured in IDLE or DONE only.
- `a` out 1: stimulus to the unit's `a` input.
- `b` out 1: stimulus to the unit's `b` input.
- `dut_out` in 1: unit's `out`, sampled by this block.
- `busy` out 1: high while a run is in progress.
- `done` out 1: high from run completion until the next accepted `start` or `rst`.
- `pass` out 1: valid when `done`; 1 iff `captured == EXPECTED`.
- `captured` out 4: bit k holds the sampled response to vector k.
- `mismatch` out 4: `captured ^ EXPECTED` over vectors already sampled; unsampled bits read 0.

## Operation
- States: IDLE, DRIVE, DONE.
- IDLE → DRIVE on `start`: vector index ← 0, hold counter ← 0, `captured` ← 0, `mismatch` ← 0, `done` ← 0.
- DRIVE: `a` = index[1], `b` = index[0], both registered, so there are no combinational paths from `start` to stimulus.
  - Hold counter increments every cycle.
  - On the cycle where counter == HOLD_CYCLES−1: `captured[index]` ← `dut_out`, `mismatch[index]` ← `dut_out ^ EXPECTED[index]`, counter ← 0.
  - If index == 3, go to DONE; otherwise index increments.
- DONE: `done` = 1, `pass` = (mismatch == 0), `a`/`b` return to 0. `start` re-enters DRIVE as from IDLE.
- `start` during DRIVE is ignored; the run is not restarted.
- `busy` = 1 exactly in DRIVE.
- Index is 2 bits and never wraps past 3; the exit is explicit.

## Timing
- Reset values: state IDLE; `a`, `b`, `busy`, `done`, `pass` = 0; `captured`, `mismatch` = 4'b0000; counters = 0.
- Let edge 0 be the edge that accepts `start`. Vector k is driven from edge k·H+1 through edge (k+1)·H, where H = HOLD_CYCLES.
- Vector k is sampled at edge (k+1)·H. `dut_out` must be settled by that edge.
- `done`/`pass` are valid from edge 4H+1. Total run latency is 4H+1 cycles.
- H = 1: each vector lasts one cycle and is sampled at the edge after it is applied, which covers the zero-delay combinational path.
- `rst` mid-run: at the next edge, return to IDLE with all outputs at reset values. A partial result is never reported.
- `rst` and `start` in the same cycle: `rst` wins.

## Configuration
- `TT_CHECKER_STOP_ON_FAIL_EN` defined:
  - The first mismatching sample moves DRIVE → DONE at the same edge that captures it.
  - Remaining `captured`/`mismatch` bits stay 0 and `pass` = 0.
  - `done` is valid at edge (k+1)·H+1 for failing vector k.
- Undefined: all four vectors always run, so the full response map is available for debug.

## Structure
- Package `tt_checker_pkg` holds:
  - the state enum (IDLE, DRIVE, DONE);
  - `NUM_VECTORS` = 4;
  - the vector index width (2).
- Counter width is $clog2(HOLD_CYCLES+1), derived locally.
- Sub-module `tt_hold_timer`: parameterised down-counter with clear input and terminal-count pulse output. It produces the sample strobe.

## Test plan
- XOR unit, EXPECTED=4'b0110, H=10: pulse `start`. Required: `a,b` = 00/01/10/11 for 10 cycles each; `captured`=0110, `pass`=1, `done` at cycle 41.
- AND unit against EXPECTED=4'b0110: required `captured`=1000, `mismatch`=1110, `pass`=0.
  - With `TT_CHECKER_STOP_ON_FAIL_EN`: `done` at cycle 21, `captured`=0000, `mismatch`=0010.
- H=1, OR unit, EXPECTED=4'b1110: required `done` at cycle 5, `pass`=1.
- Assert `rst` at cycle 17 of a run: required all outputs zero at cycle 18 and state IDLE. A new `start` then completes normally.
- `start` held high through a whole run: required exactly one run (no restart while `busy`), then a new run begins from DONE on the following cycle.
